// File: rtl/seq_restoring_divider.sv
// ---------------------------------------------------------------------------
// seq_restoring_divider
//
// Sequential unsigned restoring divider. It divides a DIVIDEND_W-bit dividend
// by a DIVISOR_W-bit divisor and produces one quotient bit per clock. It is
// the inverse of the 4x4 array multiplier in the arithmetic tile: an 8-bit
// product-width dividend over a 4-bit operand gives an 8-bit quotient and a
// 4-bit remainder.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous reset, active-high
//   start        request; sampled only when not iterating (IDLE or DONE)
//   dividend     unsigned dividend, captured on an accepted start
//   divisor      unsigned divisor, captured on an accepted start
//   busy         high while iterating
//   done         one-cycle pulse when the results become valid
//   quotient     result, held until the next completion
//   remainder    result, held until the next completion
//   div_by_zero  set together with done when the captured divisor was zero
// ---------------------------------------------------------------------------
module seq_restoring_divider #(
  parameter int DIVIDEND_W = 8,
  parameter int DIVISOR_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]            state;
  logic [DIVIDEND_W-1:0] dvd_sh;
  logic [DIVIDEND_W-1:0] quo_sh;
  logic [DIVISOR_W-1:0]  dvs;
  logic [DIVISOR_W:0]    part_rem;
  logic [CNT_W-1:0]      cnt;

  logic [DIVISOR_W:0]    trial;
  logic                  fits;
  logic [DIVISOR_W:0]    next_rem;
  logic [DIVIDEND_W-1:0] next_quo;

  // One restoring step. The partial remainder is kept one bit wider than the
  // divisor so the shifted-in value can be compared before it is reduced; after
  // every step it is below the divisor again, so its top bit never carries
  // information into the next shift.
  always_comb begin
    trial    = {part_rem[DIVISOR_W-1:0], dvd_sh[DIVIDEND_W-1]};
    fits     = (trial >= {1'b0, dvs});
    next_rem = fits ? (trial - {1'b0, dvs}) : trial;
    next_quo = {quo_sh[DIVIDEND_W-2:0], fits};
  end

  // Control and datapath. A zero divisor skips iteration entirely and reports
  // an all-ones quotient with the low dividend bits as remainder. Result
  // outputs are only written on completion so they stay valid while the next
  // operation runs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      dvd_sh      <= '0;
      quo_sh      <= '0;
      dvs         <= '0;
      part_rem    <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            dvd_sh      <= dividend;
            dvs         <= divisor;
            div_by_zero <= (divisor == '0);
            if (divisor != '0) begin
              state    <= ST_RUN;
              cnt      <= CNT_W'(DIVIDEND_W - 1);
              part_rem <= '0;
              quo_sh   <= '0;
            end else begin
              state     <= ST_DONE;
              quotient  <= '1;
              remainder <= dividend[DIVISOR_W-1:0];
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          dvd_sh   <= dvd_sh << 1;
          part_rem <= next_rem;
          quo_sh   <= next_quo;
          cnt      <= cnt - 1'b1;
          if (cnt == '0) begin
            state     <= ST_DONE;
            quotient  <= next_quo;
            remainder <= next_rem[DIVISOR_W-1:0];
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_seq_restoring_divider.sv
// ---------------------------------------------------------------------------
// tb_seq_restoring_divider
//
// Bench for seq_restoring_divider. Operations are issued from a vector table
// and from an exhaustive operand sweep; every accepted operation pushes its
// expected result onto a scoreboard queue, and a monitor on the falling edge
// pops and compares whenever done is seen, also checking latency, busy length
// and that outputs hold their previous values while iterating.
// ---------------------------------------------------------------------------
module tb_seq_restoring_divider;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  seq_restoring_divider #(
    .DIVIDEND_W(8),
    .DIVISOR_W (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  typedef struct {
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic [7:0] q;
    logic [3:0] r;
    logic       z;
  } vec_t;

  typedef struct {
    logic [7:0] q;
    logic [3:0] r;
    logic       z;
    int         accept;
    int         lat;
    int         busy_n;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[8];

  int cycle = 0;
  int pass_cnt = 0;
  int total_cnt = 0;
  int busy_cnt = 0;
  logic [7:0] held_q = '0;
  logic [3:0] held_r = '0;

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle index, equal to the number of rising edges seen so far.
  always @(posedge clk) cycle = cycle + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    total_cnt++;
    if (actual == expected) pass_cnt++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycle);
  endtask

  // Drives a one-cycle start at posedge+1 and records the expected result.
  // Returns at posedge+1 just after the accepting edge.
  task automatic applyStimulus(input logic [7:0] a, input logic [3:0] b,
                               input logic [7:0] q, input logic [3:0] r, input logic z);
    exp_t e;
    e.q      = q;
    e.r      = r;
    e.z      = z;
    e.accept = cycle + 1;
    e.lat    = z ? 0 : 8;
    e.busy_n = z ? 0 : 8;
    sb.push_back(e);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 8'($urandom);
    divisor  = 4'($urandom);
  endtask

  // Waits (bounded) until done is seen at posedge+1.
  task automatic waitDone(input int limit);
    bit seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      if (done) seen = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    if (!seen) begin
      total_cnt++;
      $display("[TB] FAIL done_timeout: done=0 after %0d cycles, required done=1", limit);
    end
  endtask

  // Scoreboard monitor on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      busy_cnt = 0;
      held_q   = '0;
      held_r   = '0;
    end else begin
      if (busy) begin
        busy_cnt++;
        checkOutput("hold_quotient", quotient, held_q);
        checkOutput("hold_remainder", remainder, held_r);
      end
      if (done) begin
        if (sb.size() == 0) begin
          total_cnt++;
          $display("[TB] FAIL unexpected_done: done=1, required 0 with no pending op (cycle %0d)", cycle);
        end else begin
          mon_e = sb.pop_front();
          checkOutput("quotient", quotient, mon_e.q);
          checkOutput("remainder", remainder, mon_e.r);
          checkOutput("div_by_zero", div_by_zero, mon_e.z);
          checkOutput("latency", cycle - mon_e.accept, mon_e.lat);
          checkOutput("busy_cycles", busy_cnt, mon_e.busy_n);
          held_q = mon_e.q;
          held_r = mon_e.r;
        end
        busy_cnt = 0;
      end
    end
  end

  initial begin
    vecs[0] = '{8'd200, 4'd7,  8'd28,  4'd4, 1'b0};
    vecs[1] = '{8'd255, 4'd1,  8'd255, 4'd0, 1'b0};
    vecs[2] = '{8'd15,  4'd15, 8'd1,   4'd0, 1'b0};
    vecs[3] = '{8'd5,   4'd9,  8'd0,   4'd5, 1'b0};
    vecs[4] = '{8'd0,   4'd3,  8'd0,   4'd0, 1'b0};
    vecs[5] = '{8'hA7,  4'd0,  8'hFF,  4'd7, 1'b1};
    vecs[6] = '{8'd100, 4'd10, 8'd10,  4'd0, 1'b0};
    vecs[7] = '{8'd9,   4'd4,  8'd2,   4'd1, 1'b0};

    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #12;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_quotient", quotient, 0);
    checkOutput("reset_remainder", remainder, 0);
    checkOutput("reset_div_by_zero", div_by_zero, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic operation, then boundary operands back-to-back in each done cycle.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i].dividend, vecs[i].divisor, vecs[i].q, vecs[i].r, vecs[i].z);
      waitDone(20);
    end

    // Divide by zero, then a normal operation that clears the flag.
    for (int i = 5; i < 7; i++) begin
      applyStimulus(vecs[i].dividend, vecs[i].divisor, vecs[i].q, vecs[i].r, vecs[i].z);
      waitDone(20);
    end
    @(posedge clk);
    #1;

    // Start while busy must be ignored.
    applyStimulus(vecs[0].dividend, vecs[0].divisor, vecs[0].q, vecs[0].r, vecs[0].z);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    dividend = 8'd99;
    divisor  = 4'd2;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 8'd1;
    divisor  = 4'd1;
    waitDone(20);
    repeat (12) begin
      @(posedge clk);
      #1;
    end

    // Asynchronous reset mid-iteration.
    applyStimulus(vecs[0].dividend, vecs[0].divisor, vecs[0].q, vecs[0].r, vecs[0].z);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst = 1'b1;
    #1;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_done", done, 0);
    checkOutput("abort_quotient", quotient, 0);
    checkOutput("abort_remainder", remainder, 0);
    checkOutput("abort_div_by_zero", div_by_zero, 0);
    sb.delete();
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
    repeat (12) begin
      @(posedge clk);
      #1;
    end
    applyStimulus(vecs[7].dividend, vecs[7].divisor, vecs[7].q, vecs[7].r, vecs[7].z);
    waitDone(20);

    // Exhaustive operand sweep against a reference model, back-to-back.
    for (int b = 0; b < 16; b++) begin
      for (int a = 0; a < 256; a++) begin
        logic [7:0] ea;
        logic [3:0] eb;
        logic [7:0] eq;
        logic [3:0] er;
        ea = 8'(a);
        eb = 4'(b);
        if (b == 0) begin
          eq = 8'hFF;
          er = ea[3:0];
        end else begin
          eq = 8'(a / b);
          er = 4'(a % b);
        end
        applyStimulus(ea, eb, eq, er, (b == 0));
        waitDone(20);
      end
    end

    repeat (3) begin
      @(posedge clk);
      #1;
    end
    checkOutput("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
